wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter_if.sv | 24 ++
 rtl/wb_port_arbiter.sv | 120 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback port bundle: ALU/MDU result requests in, register-file write port and stall out.
interface wb_port_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        mdu_valid;
  logic [4:0]  mdu_rd;
  logic [31:0] mdu_data;
  logic        mdu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;

  modport master (
    output alu_valid, alu_rd, alu_data, mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mdu_valid, mdu_rd, mdu_data,
    output mdu_ready, rf_we, rf_waddr, rf_wdata, pipe_stall
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Single-port register-file writeback arbiter: ALU priority, 2-entry MDU buffer with forced drain.
// Define WB_BYPASS_EN to write an MDU result straight through when the buffer is empty and the port is free.
module wb_port_arbiter #(
  parameter int unsigned WAIT_LIMIT = 3
) (
  input logic              clk,
  input logic              reset,
  wb_port_arbiter_if.slave bus
);

  typedef enum logic {NORMAL, DRAIN} state_e;

  localparam logic [2:0] LIMIT = 3'(WAIT_LIMIT);

  state_e      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic [2:0]  wait_q, wait_d;
  logic [4:0]  rd_q [2];
  logic [4:0]  rd_d [2];
  logic [31:0] data_q [2];
  logic [31:0] data_d [2];
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q, rf_waddr_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        stall_q, stall_d;

  logic alu_grant, head_grant, accept, store, bypass;

  assign bus.mdu_ready  = !reset || (count_q != 2'd2);
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.pipe_stall = stall_q;

  always_comb begin
    alu_grant  = 1'b0;
    head_grant = 1'b0;
    if (state_q == DRAIN) begin
      head_grant = (count_q != 2'd0);
    end else if (bus.alu_valid && (bus.alu_rd != '0)) begin
      alu_grant = 1'b1;
    end else begin
      head_grant = (count_q != 2'd0);
    end

    accept = bus.mdu_valid && (count_q != 2'd2);
    store  = accept && (bus.mdu_rd != '0);
`ifdef WB_BYPASS_EN
    bypass = store && (count_q == 2'd0) && (state_q == NORMAL) && !alu_grant;
`else
    bypass = 1'b0;
`endif

    rf_we_d    = 1'b1;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_grant) begin
      rf_waddr_d = bus.alu_rd;
      rf_wdata_d = bus.alu_data;
    end else if (head_grant) begin
      rf_waddr_d = rd_q[0];
      rf_wdata_d = data_q[0];
    end else if (bypass) begin
      rf_waddr_d = bus.mdu_rd;
      rf_wdata_d = bus.mdu_data;
    end else begin
      rf_we_d = 1'b0;
    end

    // Pop shifts first, so a same-edge push lands behind any surviving entry.
    rd_d    = rd_q;
    data_d  = data_q;
    count_d = count_q;
    if (head_grant) begin
      rd_d[0]   = rd_q[1];
      data_d[0] = data_q[1];
      count_d   = count_q - 2'd1;
    end
    if (store && !bypass) begin
      rd_d[count_d[0]]   = bus.mdu_rd;
      data_d[count_d[0]] = bus.mdu_data;
      count_d            = count_d + 2'd1;
    end

    if ((count_q == 2'd0) || head_grant) wait_d = '0;
    else                                 wait_d = wait_q + 3'd1;

    state_d = NORMAL;
    stall_d = 1'b0;
    if ((state_q == NORMAL) && (wait_d == LIMIT)) begin
      state_d = DRAIN;
      stall_d = 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      state_q    <= NORMAL;
      count_q    <= '0;
      wait_q     <= '0;
      rd_q       <= '{default: '0};
      data_q     <= '{default: '0};
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      stall_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      rd_q       <= rd_d;
      data_q     <= data_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      stall_q    <= stall_d;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scenario bench for wb_port_arbiter: expected writes queued as stimulus is driven, checked as rf_we fires.
module tb_wb_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [36:0] sb [$];

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.WAIT_LIMIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Outputs update on the falling edge; observe them half a period later.
  always @(posedge clk) begin
    if (bus.rf_we === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_write", 64'({bus.rf_waddr, bus.rf_wdata}), '1);
      end else begin
        check("write_order", 64'({bus.rf_waddr, bus.rf_wdata}), 64'(sb.pop_front()));
      end
    end
  end

  logic [4:0]  mrd  [3] = '{5'd10, 5'd11, 5'd12};
  logic [31:0] mdat [3] = '{32'hA0, 32'hB0, 32'hC0};
  int          s4_src [13] = '{0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0, 0, 3};
  logic        s4_rdy [13] = '{1, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  logic        s4_stl [13] = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0};
  logic        s3_stl [6]  = '{0, 0, 0, 1, 0, 0};
  logic [4:0]  s3_adr [6]  = '{5'd1, 5'd1, 5'd1, 5'd1, 5'd9, 5'd1};

  initial begin
    int  p;
    logic acc;

    reset         = 1'b0;
    bus.alu_valid = 1'b0;
    bus.alu_rd    = '0;
    bus.alu_data  = '0;
    bus.mdu_valid = 1'b1;
    bus.mdu_rd    = 5'd4;
    bus.mdu_data  = 32'h4444;
    tick();
    tick();
    check("rst_we", 64'(bus.rf_we), 0);
    check("rst_waddr", 64'(bus.rf_waddr), 0);
    check("rst_wdata", 64'(bus.rf_wdata), 0);
    check("rst_stall", 64'(bus.pipe_stall), 0);
    check("rst_ready", 64'(bus.mdu_ready), 1);
    reset         = 1'b1;
    bus.mdu_valid = 1'b0;
    tick();
    check("rst_no_push", 64'(bus.rf_we), 0);

    // ALU-only write, one-edge latency
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hAA;
    sb.push_back({5'd5, 32'hAA});
    tick();
    check("s1_we", 64'(bus.rf_we), 1);
    check("s1_waddr", 64'(bus.rf_waddr), 5);
    check("s1_wdata", 64'(bus.rf_wdata), 32'hAA);
    bus.alu_valid = 1'b0;
    tick();
    check("s1_idle", 64'(bus.rf_we), 0);

    // Simultaneous ALU and MDU: ALU first, MDU next edge
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'h33;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'h1234;
    sb.push_back({5'd3, 32'h33});
    sb.push_back({5'd7, 32'h1234});
    tick();
    check("s2_first", 64'(bus.rf_waddr), 3);
    bus.alu_valid = 1'b0; bus.mdu_valid = 1'b0;
    tick();
    check("s2_second_we", 64'(bus.rf_we), 1);
    check("s2_second", 64'({bus.rf_waddr, bus.rf_wdata}), 64'({5'd7, 32'h1234}));
    tick();
    check("s2_idle", 64'(bus.rf_we), 0);

    // Starved MDU result forces a drain after WAIT_LIMIT waiting edges
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h99;
    for (int e = 0; e < 6; e++) begin
      if (e == 4) sb.push_back({5'd9, 32'h99});
      else        sb.push_back({5'd1, 32'h11});
      tick();
      bus.mdu_valid = 1'b0;
      check("s3_stall", 64'(bus.pipe_stall), 64'(s3_stl[e]));
      check("s3_waddr", 64'(bus.rf_waddr), 64'(s3_adr[e]));
    end
    bus.alu_valid = 1'b0;
    tick();
    check("s3_idle", 64'(bus.rf_we), 0);

    // Three MDU results under continuous ALU traffic, producer honours mdu_ready
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
    p = 0;
    for (int e = 0; e < 13; e++) begin
      bus.mdu_valid = (p < 3);
      if (p < 3) begin
        bus.mdu_rd   = mrd[p];
        bus.mdu_data = mdat[p];
      end
      if (s4_src[e] == 0) sb.push_back({5'd2, 32'h22});
      else                sb.push_back({mrd[s4_src[e]-1], mdat[s4_src[e]-1]});
      acc = bus.mdu_valid && bus.mdu_ready;
      tick();
      if (acc) p++;
      check("s4_ready", 64'(bus.mdu_ready), 64'(s4_rdy[e]));
      check("s4_stall", 64'(bus.pipe_stall), 64'(s4_stl[e]));
    end
    check("s4_accepted", 64'(p), 3);
    bus.alu_valid = 1'b0; bus.mdu_valid = 1'b0;
    tick();
    check("s4_idle", 64'(bus.rf_we), 0);

    // Writes to r0 from either source never reach the register file
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'h66;
    for (int e = 0; e < 3; e++) begin
      tick();
      check("s5_no_we", 64'(bus.rf_we), 0);
      check("s5_ready", 64'(bus.mdu_ready), 1);
    end
    bus.alu_valid = 1'b0; bus.mdu_valid = 1'b0;
    tick();
    check("s5_idle", 64'(bus.rf_we), 0);

    // Reset while draining a full buffer
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd13; bus.mdu_data = 32'hD0;
    for (int e = 0; e < 4; e++) begin
      sb.push_back({5'd4, 32'h44});
      tick();
      if (e == 0) begin
        bus.mdu_rd = 5'd14; bus.mdu_data = 32'hE0;
      end else begin
        bus.mdu_valid = 1'b0;
      end
    end
    check("s6_drain_stall", 64'(bus.pipe_stall), 1);
    check("s6_full", 64'(bus.mdu_ready), 0);
    reset = 1'b0;
    #1;
    check("s6_ready_in_rst", 64'(bus.mdu_ready), 1);
    tick();
    check("s6_we", 64'(bus.rf_we), 0);
    check("s6_waddr", 64'(bus.rf_waddr), 0);
    check("s6_wdata", 64'(bus.rf_wdata), 0);
    check("s6_stall", 64'(bus.pipe_stall), 0);
    reset = 1'b1;
    bus.alu_valid = 1'b0;
    for (int e = 0; e < 3; e++) begin
      tick();
      check("s6_flushed", 64'(bus.rf_we), 0);
    end
    check("s6_ready_after", 64'(bus.mdu_ready), 1);

    @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
